dmem_loader: RTL
================

# dmem_loader

Byte-stream boot loader that sits directly upstream of the data memory's write port. It assembles incoming bytes, e.g. from a UART receiver, into `DATA_W`-bit words and writes them into consecutive data-memory locations. It holds the CPU in reset or stall until the image is in place. One load session per `start` pulse; the session is described by an in-band header word.

## Interface
Parameters:
- `DATA_W`, default 32 (from `def.h`): memory word width; fixed at 32 for this block.
- `DEPTH`, default `` `DEPTH`` (from `def.h`): number of data-memory words; used for range check.
- `ADDR_W`, default 16: data-memory address width, matching the 16-bit memory address port.

Ports:
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a session; sampled only in IDLE, DONE or ERR.
- `in_byte`, input, 8: stream byte.
- `in_valid`, input, 1: `in_byte` valid.
- `in_ready`, output, 1: loader accepts byte; transfer when `in_valid && in_ready`.
- `dm_a`, output, `ADDR_W`: data-memory write address.
- `dm_wd`, output, `DATA_W`: data-memory write data.
- `dm_we`, output, 1: data-memory write enable, one-cycle pulses.
- `busy`, output, 1: session in progress; CPU stall/hold.
- `done`, output, 1: last session completed without error; level.
- `err`, output, 1: last session aborted or failed; level.
- `words_loaded`, output, 16: data words written in current or last session.

## Operation
- States: IDLE, HDR, DATA, CSUM (only with the configuration macro), DONE, ERR.
- IDLE/DONE/ERR with `start`=1 → HDR; clears `done`, `err`, `words_loaded` and the byte counter.
- Byte assembly is big-endian: the first byte of each group goes to [31:24] and the fourth to [7:0]. A 2-bit byte counter wraps after each 4th byte.
- HDR: after 4 bytes, header = {base[15:0], count[15:0]}.
  - If `base + count > DEPTH`, computed in 17 bits, → ERR. No writes occur.
  - Else if `count == 0` → CSUM if enabled, otherwise DONE.
  - Else → DATA.
- DATA: word i (0-based) is written to `base + i`. After word `count-1` is written → CSUM/DONE.
- `busy` = 1 in HDR, DATA and CSUM. `in_ready` = `busy`.
- `start` while busy is ignored.
- Bytes offered in IDLE/DONE/ERR are not accepted (`in_ready`=0).
- Reset mid-session: all state returns to reset values. Words already written stay in memory; no further writes.

## Timing
- Reset values: `in_ready`=0, `dm_we`=0, `dm_a`=0, `dm_wd`=0, `busy`=0, `done`=0, `err`=0, `words_loaded`=0, state IDLE.
- `start` accepted on edge t → `busy`=1 and `in_ready`=1 from t+1.
- 4th byte of a data word accepted on edge t → at t+1 `dm_we`=1 for exactly one cycle, with registered `dm_a`/`dm_wd`. `words_loaded` increments at the same edge.
- `in_ready` stays high during the write cycle. Byte acceptance and write overlap, so sustained throughput is 1 byte/cycle.
- Final write at t+1 → `busy`=0 and `done`=1 (or entry to CSUM) at t+1.
- Range failure: 4th header byte accepted on edge t → `err`=1 and `busy`=0 at t+1.
- `in_valid` gaps: assembly simply pauses; there is no timeout.

## Configuration
- `DMEM_LOADER_CSUM_EN` defined:
  - After the data words, a 4-byte trailer word is expected (CSUM state).
  - Trailer must equal the mod-2^32 sum of the header word and all data words.
  - Match → DONE. Mismatch → ERR, `err`=1; data remains written.
  - DONE/ERR is reached the cycle after the 4th trailer byte.
- Undefined: no CSUM state and no trailer; DATA → DONE directly.

## Structure
- Shared package/header (`def.h`): `DATA_W`, `DEPTH`, and state encodings `LD_IDLE`, `LD_HDR`, `LD_DATA`, `LD_CSUM`, `LD_DONE`, `LD_ERR`.
- One natural sub-module: `byte_packer`, which holds the 4-byte shift register and byte counter and emits `word` plus a one-cycle `word_valid`. The FSM, address counter and checksum live in `dmem_loader`.

## Test plan
- Header 0x0000_0003, data 0x070b0001, 0x00020003, 0x01020203, sent back-to-back → writes at addresses 0, 1, 2 on consecutive 4-cycle slots, `words_loaded`=3, `done`=1, `busy`=0.
- Header 0x0010_0002 with `in_valid` toggling every other cycle → writes to 0x10 and 0x11 only, correct word values, `done`=1.
- Header base + count = `DEPTH`+1 → `err`=1, zero `dm_we` pulses, `in_ready`=0 afterwards.
- Header 0x0000_0000 → `done`=1 the cycle after the 4th header byte (no CSUM build), or after a 0x00000000 trailer (CSUM build).
- `rst` asserted after the 2nd data word → all outputs at reset values next cycle; a new `start` plus a full image loads correctly.
- CSUM build: correct trailer → `done`=1; trailer off by 1 → `err`=1 and `words_loaded`=count.

Source files
------------

// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory boot loader: word width, memory
// depth, FSM state encodings and the header range-check helper.
package dmem_loader_pkg;

  localparam int LD_DATA_W = 32;
  localparam int LD_DEPTH  = 1024;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HDR  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_e;

  // The sum is formed in 17 bits so that a base near 0xFFFF cannot wrap
  // around into an apparently valid small range.
  function automatic logic hdr_in_range(input logic [15:0] base,
                                        input logic [15:0] count,
                                        input logic [16:0] depth);
    logic [16:0] end_s;
    end_s = {1'b0, base} + {1'b0, count};
    return (end_s <= depth);
  endfunction

endpackage

// File: rtl/dmem_loader_byte_packer.sv
// Big-endian byte-to-word packer. The first three bytes of a group are held
// in a shift register; the group completes combinationally with the fourth
// byte, so the consumer can register the word on the same edge that accepts
// that byte.
module dmem_loader_byte_packer
  import dmem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic [LD_DATA_W-1:0] word_o,
  output logic                 word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q,   cnt_d;

  // Next-state for the shift register and the wrapping byte counter.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = 24'd0;
      cnt_d   = 2'd0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Shift register and byte counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= 24'd0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i & ~clr_i & (cnt_q == 2'd3);

endmodule

// File: rtl/dmem_loader.sv
// Byte-stream boot loader feeding the data-memory write port.
// A session starts with a header word {base, count}, followed by count data
// words written to base, base+1, ... Optional feature macro
// DMEM_LOADER_CSUM_EN adds a trailer word that must equal the mod-2^32 sum
// of the header and all data words.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int DATA_W = LD_DATA_W,
  parameter int DEPTH  = LD_DEPTH,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] dm_a,
  output logic [DATA_W-1:0] dm_wd,
  output logic              dm_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

`ifdef DMEM_LOADER_CSUM_EN
  localparam ld_state_e AFTER_DATA = LD_CSUM;
`else
  localparam ld_state_e AFTER_DATA = LD_DONE;
`endif

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       wl_q,    wl_d;
  logic [ADDR_W-1:0] dm_a_q,  dm_a_d;
  logic [DATA_W-1:0] dm_wd_q, dm_wd_d;
  logic              dm_we_q, dm_we_d;
`ifdef DMEM_LOADER_CSUM_EN
  logic [31:0]       sum_q,   sum_d;
`endif

  logic              busy_s;
  logic              accept_s;
  logic              start_acc_s;
  logic [31:0]       word_s;
  logic              word_valid_s;

  assign busy_s      = (state_q == LD_HDR) || (state_q == LD_DATA) || (state_q == LD_CSUM);
  assign accept_s    = in_valid & busy_s;
  assign start_acc_s = start & ((state_q == LD_IDLE) || (state_q == LD_DONE) || (state_q == LD_ERR));

  dmem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_acc_s),
    .byte_valid_i (accept_s),
    .byte_i       (in_byte),
    .word_o       (word_s),
    .word_valid_o (word_valid_s)
  );

  // Session FSM: header decode, address sequencing, write strobes and checksum.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wl_d    = wl_q;
    dm_a_d  = dm_a_q;
    dm_wd_d = dm_wd_q;
    dm_we_d = 1'b0;
`ifdef DMEM_LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d = LD_HDR;
          wl_d    = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      LD_HDR: begin
        if (word_valid_s) begin
          count_d = word_s[15:0];
          addr_d  = ADDR_W'(word_s[31:16]);
`ifdef DMEM_LOADER_CSUM_EN
          sum_d   = word_s;
`endif
          if (!hdr_in_range(word_s[31:16], word_s[15:0], 17'(DEPTH))) begin
            state_d = LD_ERR;
          end else if (word_s[15:0] == 16'd0) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = LD_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      LD_DATA: begin
        if (word_valid_s) begin
          dm_we_d = 1'b1;
          dm_a_d  = addr_q;
          dm_wd_d = DATA_W'(word_s);
          addr_d  = addr_q + ADDR_W'(1);
          wl_d    = wl_q + 16'd1;
`ifdef DMEM_LOADER_CSUM_EN
          sum_d   = sum_q + word_s;
`endif
          if ((wl_q + 16'd1) == count_q) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = LD_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
`ifdef DMEM_LOADER_CSUM_EN
      LD_CSUM: begin
        if (word_valid_s) begin
          if (word_s == sum_q) begin
            state_d = LD_DONE;
          end else begin
            state_d = LD_ERR;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any session in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      count_q <= 16'd0;
      wl_q    <= 16'd0;
      dm_a_q  <= '0;
      dm_wd_q <= '0;
      dm_we_q <= 1'b0;
`ifdef DMEM_LOADER_CSUM_EN
      sum_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wl_q    <= wl_d;
      dm_a_q  <= dm_a_d;
      dm_wd_q <= dm_wd_d;
      dm_we_q <= dm_we_d;
`ifdef DMEM_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready     = busy_s;
  assign busy         = busy_s;
  assign done         = (state_q == LD_DONE);
  assign err          = (state_q == LD_ERR);
  assign dm_a         = dm_a_q;
  assign dm_wd        = dm_wd_q;
  assign dm_we        = dm_we_q;
  assign words_loaded = wl_q;

endmodule
